// File: rtl/rkob_ptp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rkob_ptp_pkg
//  Description : Shared defaults for the rkob_ptp FIFO controller and its
//                storage RAM (word width, pointer width, depth, count width).
//  Revision    : 1.0 - initial release
// ============================================================================
package rkob_ptp_pkg;

    localparam int c_data_width = 52;
    localparam int c_addr_width = 12;
    localparam int c_mem_depth  = 1 << c_addr_width;
    // Count needs one more bit than the pointers to represent a full FIFO.
    localparam int c_cnt_width  = c_addr_width + 1;

endpackage : rkob_ptp_pkg
`default_nettype wire

// File: rtl/rkob_ptp_ram.sv
`default_nettype none
// ============================================================================
//  Module      : rkob_ptp_ram
//  Description : Simple dual-port storage for the FIFO. Synchronous write,
//                registered read address, one-cycle read latency.
//                Contents are never reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module rkob_ptp_ram
    import rkob_ptp_pkg::*;
#(
    parameter int DATA_WIDTH = c_data_width,
    parameter int ADDR_WIDTH = c_addr_width,
    parameter int MEM_DEPTH  = c_mem_depth
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [0:MEM_DEPTH-1];
    logic [ADDR_WIDTH-1:0] r_rd_addr;

    // Write port: store the word on an accepted push.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Capture the read address on an accepted pop; data follows next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_addr <= '0;
        end else if (rd_en) begin
            r_rd_addr <= rd_addr;
        end
    end

    assign rd_data = r_mem[r_rd_addr];

endmodule : rkob_ptp_ram
`default_nettype wire

// File: rtl/rkob_ptp_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rkob_ptp_fifo_ctrl
//  Description : Synchronous FIFO controller with registered full/empty,
//                occupancy count, overflow/underflow pulses and optional
//                almost-full/almost-empty flags.
//                Optional feature macro: RKOB_PTP_FIFO_THRESH_EN
//                  defined   -> afull/aempty compare count to the levels
//                  undefined -> afull tied 0, aempty tied 1
//  Revision    : 1.0 - initial release
// ============================================================================
module rkob_ptp_fifo_ctrl
    import rkob_ptp_pkg::*;
#(
    parameter int DATA_WIDTH = c_data_width,
    parameter int ADDR_WIDTH = c_addr_width,
    parameter int MEM_DEPTH  = c_mem_depth,
    parameter int AFULL_LVL  = 4064,
    parameter int AEMPTY_LVL = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  afull,
    output logic                  aempty
);

    localparam int                    c_cnt_w    = ADDR_WIDTH + 1;
    localparam logic [c_cnt_w-1:0]    c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0]    c_full_cnt = c_cnt_w'(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] c_ptr_one  = ADDR_WIDTH'(1);

    // Parameter sanity: depth must be a power of two matching the pointer
    // width, and both threshold levels must lie inside the FIFO range.
    if ((MEM_DEPTH != (1 << ADDR_WIDTH)) || (AFULL_LVL > MEM_DEPTH) ||
        (AEMPTY_LVL > MEM_DEPTH)) begin : g_param_range_err
    end

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0]    r_count;
    logic [c_cnt_w-1:0]    w_count_nxt;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_rd_valid;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  w_push;
    logic                  w_pop;

    // A full FIFO still accepts a pop and an empty one still accepts a push,
    // so each request is gated only by its own flag.
    assign w_push = wr_en & ~r_full;
    assign w_pop  = rd_en & ~r_empty;

    // Next-state occupancy; simultaneous push and pop cancel out.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + c_cnt_one;
            2'b01:   w_count_nxt = r_count - c_cnt_one;
            default: w_count_nxt = r_count;
        endcase
    end

    // Pointers, count, occupancy flags, read-valid and reject pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            r_count     <= w_count_nxt;
            r_full      <= (w_count_nxt == c_full_cnt);
            r_empty     <= (w_count_nxt == '0);
            r_rd_valid  <= w_pop;
            r_overflow  <= wr_en & r_full;
            r_underflow <= rd_en & r_empty;
        end
    end

`ifdef RKOB_PTP_FIFO_THRESH_EN
    localparam logic [c_cnt_w-1:0] c_afull_lvl  = c_cnt_w'(AFULL_LVL);
    localparam logic [c_cnt_w-1:0] c_aempty_lvl = c_cnt_w'(AEMPTY_LVL);

    logic r_afull;
    logic r_aempty;

    // Threshold flags track the same next-state count as full/empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
        end else begin
            r_afull  <= (w_count_nxt >= c_afull_lvl);
            r_aempty <= (w_count_nxt <= c_aempty_lvl);
        end
    end

    assign afull  = r_afull;
    assign aempty = r_aempty;
`else
    assign afull  = 1'b0;
    assign aempty = 1'b1;
`endif

    rkob_ptp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_push),
        .wr_addr (r_wr_ptr),
        .wr_data (wr_data),
        .rd_en   (w_pop),
        .rd_addr (r_rd_ptr),
        .rd_data (rd_data)
    );

    assign rd_valid  = r_rd_valid;
    assign full      = r_full;
    assign empty     = r_empty;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule : rkob_ptp_fifo_ctrl
`default_nettype wire

// File: tb/tb_rkob_ptp_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rkob_ptp_fifo_ctrl
//  Description : Self-checking bench for rkob_ptp_fifo_ctrl: directed vector
//                table plus fill/overflow, drain/underflow, wrap and
//                mid-stream reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rkob_ptp_fifo_ctrl;

    localparam int DW    = 52;
    localparam int AW    = 12;
    localparam int DEPTH = 4096;
    localparam int AFL   = 4064;
    localparam int AEL   = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;
    logic          afull;
    logic          aempty;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] q[$];

    typedef struct {
        logic          wr;
        logic [DW-1:0] d;
        logic          rd;
        int            cnt;
        logic          full;
        logic          empty;
        logic          vld;
        logic [DW-1:0] rdat;
        logic          ovf;
        logic          unf;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    rkob_ptp_fifo_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .MEM_DEPTH  (DEPTH),
        .AFULL_LVL  (AFL),
        .AEMPTY_LVL (AEL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow),
        .afull     (afull),
        .aempty    (aempty)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_afull(input int c);
`ifdef RKOB_PTP_FIFO_THRESH_EN
        return (c >= AFL);
`else
        return (c < 0);
`endif
    endfunction

    function automatic logic exp_aempty(input int c);
`ifdef RKOB_PTP_FIFO_THRESH_EN
        return (c <= AEL);
`else
        return (c >= 0);
`endif
    endfunction

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        @(posedge clk);
        #1;
    endtask

    // One cycle against the queue reference model.
    task automatic mstep(input logic w, input logic [DW-1:0] d, input logic r);
        logic          m_full;
        logic          m_empty;
        logic          acc_push;
        logic          acc_pop;
        logic [DW-1:0] exp_d;
        m_full   = (q.size() == DEPTH);
        m_empty  = (q.size() == 0);
        acc_push = w && !m_full;
        acc_pop  = r && !m_empty;
        exp_d    = '0;
        if (acc_pop)  exp_d = q.pop_front();
        if (acc_push) q.push_back(d);
        cyc(w, d, r);
        chk("m.count", 64'(count), 64'(q.size()));
        chk("m.full", 64'(full), 64'(q.size() == DEPTH));
        chk("m.empty", 64'(empty), 64'(q.size() == 0));
        chk("m.rd_valid", 64'(rd_valid), 64'(acc_pop));
        if (acc_pop) chk("m.rd_data", 64'(rd_data), 64'(exp_d));
        chk("m.overflow", 64'(overflow), 64'(w && m_full));
        chk("m.underflow", 64'(underflow), 64'(r && m_empty));
        chk("m.afull", 64'(afull), 64'(exp_afull(q.size())));
        chk("m.aempty", 64'(aempty), 64'(exp_aempty(q.size())));
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, ".count"}, 64'(count), 64'd0);
        chk({tag, ".empty"}, 64'(empty), 64'd1);
        chk({tag, ".full"}, 64'(full), 64'd0);
        chk({tag, ".rd_valid"}, 64'(rd_valid), 64'd0);
        chk({tag, ".overflow"}, 64'(overflow), 64'd0);
        chk({tag, ".underflow"}, 64'(underflow), 64'd0);
        chk({tag, ".afull"}, 64'(afull), 64'd0);
        chk({tag, ".aempty"}, 64'(aempty), 64'd1);
    endtask

    task automatic do_reset();
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = '0;
        #2 rst  = 1'b1;
        #1;
        check_reset_state("rst");
        @(posedge clk);
        #2 rst = 1'b0;
        q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst     = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = '0;

        //                wr  data      rd   cnt full empty vld rdat      ovf   unf
        vecs[0]  = '{1'b0, 52'h0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 52'h0, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 52'h1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 52'h0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 52'h2, 1'b0, 2, 1'b0, 1'b0, 1'b0, 52'h0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 52'h3, 1'b0, 3, 1'b0, 1'b0, 1'b0, 52'h0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 52'h0, 1'b1, 2, 1'b0, 1'b0, 1'b1, 52'h1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 52'h0, 1'b1, 1, 1'b0, 1'b0, 1'b1, 52'h2, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 52'h0, 1'b1, 0, 1'b0, 1'b1, 1'b1, 52'h3, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 52'h0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 52'h0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 52'hA, 1'b1, 1, 1'b0, 1'b0, 1'b0, 52'h0, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 52'hB, 1'b1, 1, 1'b0, 1'b0, 1'b1, 52'hA, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 52'h0, 1'b1, 0, 1'b0, 1'b1, 1'b1, 52'hB, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 52'h0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 52'h0, 1'b0, 1'b0};

        // Asynchronous reset before any clock edge has been seen by the DUT.
        do_reset();

        // Directed vector table: basic order, underflow, push+pop while empty.
        for (int i = 0; i < 12; i++) begin
            cyc(vecs[i].wr, vecs[i].d, vecs[i].rd);
            chk($sformatf("vec%0d.count", i), 64'(count), 64'(vecs[i].cnt));
            chk($sformatf("vec%0d.full", i), 64'(full), 64'(vecs[i].full));
            chk($sformatf("vec%0d.empty", i), 64'(empty), 64'(vecs[i].empty));
            chk($sformatf("vec%0d.rd_valid", i), 64'(rd_valid), 64'(vecs[i].vld));
            if (vecs[i].vld) chk($sformatf("vec%0d.rd_data", i), 64'(rd_data), 64'(vecs[i].rdat));
            chk($sformatf("vec%0d.overflow", i), 64'(overflow), 64'(vecs[i].ovf));
            chk($sformatf("vec%0d.underflow", i), 64'(underflow), 64'(vecs[i].unf));
            chk($sformatf("vec%0d.afull", i), 64'(afull), 64'd0);
            chk($sformatf("vec%0d.aempty", i), 64'(aempty), 64'd1);
        end

        // Fill to capacity, overflow, push+pop at full, then drain.
        do_reset();
        for (int i = 0; i < DEPTH; i++) mstep(1'b1, DW'(i), 1'b0);
        chk("fill.full", 64'(full), 64'd1);
        chk("fill.count", 64'(count), 64'd4096);
        mstep(1'b1, 52'hDEAD, 1'b0);
        chk("ovf.pulse", 64'(overflow), 64'd1);
        chk("ovf.count", 64'(count), 64'd4096);
        mstep(1'b0, 52'h0, 1'b0);
        chk("ovf.cleared", 64'(overflow), 64'd0);
        mstep(1'b1, 52'hBEEF, 1'b1);
        chk("fullpp.overflow", 64'(overflow), 64'd1);
        chk("fullpp.count", 64'(count), 64'd4095);
        chk("fullpp.rd_data", 64'(rd_data), 64'd0);
        while (q.size() > 0) mstep(1'b0, 52'h0, 1'b1);
        mstep(1'b0, 52'h0, 1'b1);
        chk("unf.pulse", 64'(underflow), 64'd1);
        chk("unf.rd_valid", 64'(rd_valid), 64'd0);

        // Interleaved traffic long enough to wrap both pointers.
        do_reset();
        for (int i = 0; i < 5000; i++) begin
            mstep(1'b1, DW'({$urandom(), $urandom()}), (i % 8) != 7);
        end
        for (int i = 0; i < 100; i++) mstep(1'b0, 52'h0, 1'b1);
        chk("midrst.pre_valid", 64'(rd_valid), 64'd1);

        // Reset mid-stream while a pop is in flight.
        #2 rst = 1'b1;
        #1;
        chk("midrst.count", 64'(count), 64'd0);
        chk("midrst.empty", 64'(empty), 64'd1);
        chk("midrst.rd_valid", 64'(rd_valid), 64'd0);
        chk("midrst.full", 64'(full), 64'd0);
        q.delete();
        rd_en = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        mstep(1'b1, 52'h55, 1'b0);
        mstep(1'b0, 52'h0, 1'b1);
        chk("post_rst.rd_data", 64'(rd_data), 64'h55);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_rkob_ptp_fifo_ctrl
`default_nettype wire

// File: doc/rkob_ptp_fifo_ctrl.md
RKOB_PTP_FIFO_CTRL -- requirements
Module: rkob_ptp_fifo_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 52, meaning word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, meaning pointer width.
REQ-003 SHALL have parameter MEM_DEPTH, default 4096, equal to 2**ADDR_WIDTH, meaning capacity in words.
REQ-004 SHALL have parameter AFULL_LVL, default 4064, meaning almost-full threshold.
REQ-005 SHALL have parameter AEMPTY_LVL, default 32, meaning almost-empty threshold.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port wr_en, input, 1 bit: push request.
REQ-009 SHALL have port wr_data, input, DATA_WIDTH bits: push data.
REQ-010 SHALL have port rd_en, input, 1 bit: pop request.
REQ-011 SHALL have port rd_data, output, DATA_WIDTH bits: popped word.
REQ-012 SHALL have port rd_valid, output, 1 bit: rd_data is valid this cycle.
REQ-013 SHALL have ports full and empty, output, 1 bit each: occupancy flags.
REQ-014 SHALL have port count, output, ADDR_WIDTH+1 bits: stored word count.
REQ-015 SHALL have ports overflow and underflow, output, 1 bit each: one-cycle pulses for rejected requests.
REQ-016 SHALL have ports afull and aempty, output, 1 bit each: threshold flags (see Configuration).

Function
REQ-017 SHALL accept a push when wr_en=1 and full=0; the word is written at the write pointer, which then increments.
REQ-018 SHALL accept a pop when rd_en=1 and empty=0; the RAM read address is the read pointer, which then increments.
REQ-019 SHALL present a popped word on rd_data with rd_valid=1 exactly one cycle after the accepted pop, with no bubbles on back-to-back pops.
REQ-020 SHALL wrap both pointers modulo MEM_DEPTH.
REQ-021 SHALL update count as +1 on push only, -1 on pop only, and unchanged on simultaneous accepted push and pop.
REQ-022 SHALL register full (count==MEM_DEPTH) and empty (count==0), both derived from next-state count.
REQ-023 SHALL, when full and both wr_en and rd_en are asserted, accept the pop, reject the push, and pulse overflow.
REQ-024 SHALL, when empty and both are asserted, accept the push, reject the pop, and pulse underflow.
REQ-025 SHALL make a word pushed in cycle N poppable from cycle N+1 (empty deasserts at N+1), with its data at N+2.
REQ-026 SHALL register overflow and underflow as single-cycle pulses in the cycle after the rejected request.

Reset
REQ-027 SHALL, on rst, asynchronously clear the pointers and count to 0, set empty=1 and aempty=1, and clear full, afull, rd_valid, overflow and underflow to 0.
REQ-028 SHALL leave RAM contents undefined or untouched on reset; a reset mid-operation discards all stored words and any in-flight read (rd_valid=0).

Configuration
REQ-029 SHALL, with RKOB_PTP_FIFO_THRESH_EN defined, register afull=(count>=AFULL_LVL) and aempty=(count<=AEMPTY_LVL).
REQ-030 SHALL, without RKOB_PTP_FIFO_THRESH_EN, tie afull to 0 and aempty to 1 and synthesize no threshold comparators.

Structure
REQ-031 SHALL place the DATA_WIDTH, ADDR_WIDTH and MEM_DEPTH defaults and the count-width constant in the shared package rkob_ptp_pkg.
REQ-032 SHALL instantiate exactly one sub-module, rkob_ptp_ram (registered read address, one-cycle read latency), as storage.

Verification
REQ-033 SHALL cover: after reset, push 0x1, 0x2, 0x3 on consecutive cycles, then pop 3 -> rd_data 0x1, 0x2, 0x3 on consecutive rd_valid cycles; count returns to 0; empty=1.
REQ-034 SHALL cover: 4096 pushes -> full=1 and count=4096; one further push -> overflow pulse; count unchanged.
REQ-035 SHALL cover: pop while empty -> underflow pulse; rd_valid stays 0.
REQ-036 SHALL cover: at count=4096, push and pop together -> pop accepted, overflow=1, count=4095.
REQ-037 SHALL cover: 5000 pushes interleaved with pops, pointers wrapped -> data order preserved; reset asserted mid-stream -> count=0, empty=1, rd_valid=0 immediately.
REQ-038 SHALL cover, with RKOB_PTP_FIFO_THRESH_EN defined: count reaching 4064 -> afull=1; count 33->32 -> aempty=1.
